// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared widths and types for the MIPS-Lite writeback stage.
//                DATA          - datapath width
//                REGISTERWIDTH - register index width
//                wb_state_t    - writeback run/halted state
//                memwb_t       - one MEM/WB pipeline register entry
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA          = 32;
    localparam int REGISTERWIDTH = 5;

    typedef enum logic [0:0] {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                     valid;
        logic                     regWrite;
        logic                     memToReg;
        logic                     halt;
        logic [REGISTERWIDTH-1:0] rd;
        logic [DATA-1:0]          aluResult;
        logic [DATA-1:0]          loadData;
    } memwb_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_reg
//  Description : MEM/WB pipeline register, one memwb_t entry wide.
//                Update priority: reset > flush > stall > capture.
//  Ports       : clk      - rising-edge clock
//                reset    - synchronous active-high reset (clears entry)
//                stall_i  - hold current entry
//                flush_i  - load a bubble (wins over stall)
//                d_i      - entry presented by the MEM stage
//                q_o      - registered entry seen by writeback
//  Revision    : 1.0 - initial release
// ============================================================================
module memwb_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall_i,
    input  logic   flush_i,
    input  memwb_t d_i,
    output memwb_t q_o
);

    memwb_t entry_q;
    memwb_t entry_d;

    // A bubble is an all-zero entry; only valid matters, but zeroing the
    // rest keeps the forwarding outputs deterministic.
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = '0;
        end else if (!stall_i) begin
            entry_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule : memwb_reg
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : MEM/WB register plus register-file write port driver.
//                Selects ALU result or load data, suppresses r0 writes,
//                and retires HALT into a sticky HALTED state.
//  Options     : WB_PERF_COUNTER_EN - adds 32-bit retireCount output
//  Ports       : clk, reset                 - clock / sync active-high reset
//                stall, flush               - MEM/WB hold / bubble control
//                memValid .. memLoadData    - instruction from MEM stage
//                writeEnable, rd, writeData - register file write port
//                halted                     - HALT has retired (sticky)
//                retireCount                - retired count (option only)
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import mips_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     memValid,
    input  logic                     memRegWrite,
    input  logic                     memToReg,
    input  logic                     memHalt,
    input  logic [REGISTERWIDTH-1:0] memRd,
    input  logic [DATA-1:0]          memAluResult,
    input  logic [DATA-1:0]          memLoadData,
    output logic                     writeEnable,
    output logic [REGISTERWIDTH-1:0] rd,
    output logic [DATA-1:0]          writeData,
    output logic                     halted
`ifdef WB_PERF_COUNTER_EN
    ,
    output logic [31:0]              retireCount
`endif
);

    memwb_t    mem_entry;
    memwb_t    wb_entry;
    wb_state_t state_q;
    wb_state_t state_d;

    assign mem_entry = '{
        valid:     memValid,
        regWrite:  memRegWrite,
        memToReg:  memToReg,
        halt:      memHalt,
        rd:        memRd,
        aluResult: memAluResult,
        loadData:  memLoadData
    };

    memwb_reg u_memwb_reg (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .flush_i (flush),
        .d_i     (mem_entry),
        .q_o     (wb_entry)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WB_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HALT moves to HALTED as soon as it sits valid in MEM/WB, regardless
    // of stall; HALTED is only left through reset.
    always_comb begin
        state_d = state_q;
        if ((state_q == WB_RUN) && wb_entry.valid && wb_entry.halt) begin
            state_d = WB_HALTED;
        end
    end

    // ---------------------------------------------------- write port
    // While stalled a valid write keeps writeEnable high; the register file
    // simply rewrites the same value each cycle.
    assign writeEnable = wb_entry.valid
                       & wb_entry.regWrite
                       & (wb_entry.rd != '0)
                       & (state_q == WB_RUN)
                       & ~wb_entry.halt;

    assign rd        = wb_entry.rd;
    assign writeData = wb_entry.memToReg ? wb_entry.loadData : wb_entry.aluResult;
    assign halted    = (state_q == WB_HALTED);

`ifdef WB_PERF_COUNTER_EN
    // ---------------------------------------------------- retire counter
    // An entry retires in the last cycle it occupies MEM/WB: when it is about
    // to be replaced (no stall) or squashed (flush). HALT counts too.
    logic        retire_event;
    logic [31:0] retire_count_q;
    logic [31:0] retire_count_d;

    assign retire_event = wb_entry.valid & (state_q == WB_RUN) & (~stall | flush);

    always_comb begin
        retire_count_d = retire_count_q;
        if (retire_event) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retireCount = retire_count_q;
`endif

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Scoreboard bench for writeback_stage. Each cycle's stimulus
//                pushes the expected write-port outputs; they are popped and
//                compared one time unit after the following rising edge.
//                A small register-file model commits the write port.
//  Options     : WB_PERF_COUNTER_EN - also checks retireCount
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        memValid;
    logic        memRegWrite;
    logic        memToReg;
    logic        memHalt;
    logic [4:0]  memRd;
    logic [31:0] memAluResult;
    logic [31:0] memLoadData;
    logic        writeEnable;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic        halted;
`ifdef WB_PERF_COUNTER_EN
    logic [31:0] retireCount;
`endif

    writeback_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .memValid     (memValid),
        .memRegWrite  (memRegWrite),
        .memToReg     (memToReg),
        .memHalt      (memHalt),
        .memRd        (memRd),
        .memAluResult (memAluResult),
        .memLoadData  (memLoadData),
        .writeEnable  (writeEnable),
        .rd           (rd),
        .writeData    (writeData),
        .halted       (halted)
`ifdef WB_PERF_COUNTER_EN
        ,
        .retireCount  (retireCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file consumer: commits the write port on each rising edge.
    logic [31:0] rf [0:31];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (writeEnable) begin
            rf[rd] <= writeData;
        end
    end

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        dc;      // rd/writeData don't-care (bubble)
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic fl,
                         input logic v, input logic rw, input logic m2r, input logic h,
                         input logic [4:0] r, input logic [31:0] alu, input logic [31:0] ld);
        reset        = rst;
        stall        = st;
        flush        = fl;
        memValid     = v;
        memRegWrite  = rw;
        memToReg     = m2r;
        memHalt      = h;
        memRd        = r;
        memAluResult = alu;
        memLoadData  = ld;
    endtask

    task automatic expect_out(input logic we, input logic [4:0] r, input logic [31:0] wd,
                              input logic dc, input logic hl, input logic [31:0] cnt);
        exp_t e;
        e.we = we; e.rd = r; e.wd = wd; e.dc = dc; e.halted = hl; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_value({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_value({tag, ".we"}, {31'd0, writeEnable}, {31'd0, e.we});
            check_value({tag, ".halted"}, {31'd0, halted}, {31'd0, e.halted});
            if (!e.dc) begin
                check_value({tag, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
                check_value({tag, ".wd"}, writeData, e.wd);
            end
`ifdef WB_PERF_COUNTER_EN
            check_value({tag, ".cnt"}, retireCount, e.cnt);
`endif
        end
    endtask

    initial begin
        // reset
        drive(1, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd0, 32'd0, 0, 0, 32'd0); tick("reset0");
        expect_out(0, 5'd0, 32'd0, 0, 0, 32'd0); tick("reset1");

        // ALU write r5, load write r7, load to r0, ALU write r3
        drive(0, 0, 0, 1, 1, 0, 0, 5'd5, 32'h0000_1234, 32'h5555_5555);
        expect_out(1, 5'd5, 32'h0000_1234, 0, 0, 32'd0); tick("alu_r5");
        drive(0, 0, 0, 1, 1, 1, 0, 5'd7, 32'h1111_1111, 32'hDEAD_BEEF);
        expect_out(1, 5'd7, 32'hDEAD_BEEF, 0, 0, 32'd1); tick("load_r7");
        check_value("rf5", rf[5], 32'h0000_1234);
        drive(0, 0, 0, 1, 1, 1, 0, 5'd0, 32'h1111_1111, 32'hDEAD_BEEF);
        expect_out(0, 5'd0, 32'hDEAD_BEEF, 0, 0, 32'd2); tick("load_r0");
        check_value("rf7", rf[7], 32'hDEAD_BEEF);
        drive(0, 0, 0, 1, 1, 0, 0, 5'd3, 32'h0000_0033, 32'd0);
        expect_out(1, 5'd3, 32'h0000_0033, 0, 0, 32'd3); tick("alu_r3");
        check_value("rf0", rf[0], 32'd0);

        // stall holds r3 for three cycles, new MEM inputs ignored
        drive(0, 1, 0, 1, 1, 0, 0, 5'd8, 32'h0000_0088, 32'd0);
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 5'd3, 32'h0000_0033, 0, 0, 32'd3); tick("stall_r3");
        end

        // flush with stall: bubble, r3 retires
        drive(0, 1, 1, 1, 1, 0, 0, 5'd8, 32'h0000_0088, 32'd0);
        expect_out(0, 5'd0, 32'd0, 1, 0, 32'd4); tick("flush");
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd0, 32'd0, 1, 0, 32'd4); tick("idle");

        // HALT sequence: r2, HALT, r4
        drive(0, 0, 0, 1, 1, 0, 0, 5'd2, 32'h0000_0022, 32'd0);
        expect_out(1, 5'd2, 32'h0000_0022, 0, 0, 32'd4); tick("alu_r2");
        drive(0, 0, 0, 1, 0, 0, 1, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd0, 32'd0, 0, 0, 32'd5); tick("halt_cap");
        drive(0, 0, 0, 1, 1, 0, 0, 5'd4, 32'h0000_0044, 32'd0);
        expect_out(0, 5'd4, 32'h0000_0044, 0, 1, 32'd6); tick("halted_r4");
        drive(0, 1, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd4, 32'h0000_0044, 0, 1, 32'd6); tick("halted_stall");
        check_value("rf2", rf[2], 32'h0000_0022);
        check_value("rf4", rf[4], 32'd0);

        // reset while halted and stalled, then a normal write to r9
        drive(1, 1, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd0, 32'd0, 0, 0, 32'd0); tick("reset_mid");
        drive(0, 0, 0, 1, 1, 0, 0, 5'd9, 32'h0000_0099, 32'd0);
        expect_out(1, 5'd9, 32'h0000_0099, 0, 0, 32'd0); tick("alu_r9");
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd0, 32'd0, 1, 0, 32'd1); tick("idle_r9");
        check_value("rf9", rf[9], 32'h0000_0099);

`ifdef WB_PERF_COUNTER_EN
        // counter wrap
        drive(0, 0, 0, 1, 1, 0, 0, 5'd10, 32'h0000_00AA, 32'd0);
        expect_out(1, 5'd10, 32'h0000_00AA, 0, 0, 32'd1); tick("alu_r10");
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        expect_out(0, 5'd0, 32'd0, 1, 0, 32'd0); tick("wrap");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire
